// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Operand source select for the EX-stage ALU inputs
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Memory-freeze sequencer states
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    // Instruction the IF/ID register injects when flushed (addi x0, x0, 0)
    localparam logic [31:0] NOP_INST = 32'h00000013;

    // True when a writing stage targets a real register that matches a source index
    function automatic logic regMatch(input logic we, input reg_idx_t rd, input reg_idx_t rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of stage-side inputs and control outputs of the hazard controller.
// The datapath side uses the master modport, the controller the slave modport.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);

    // Decode stage
    reg_idx_t          rs1_d;
    reg_idx_t          rs2_d;
    // Execute stage
    reg_idx_t          rs1_e;
    reg_idx_t          rs2_e;
    reg_idx_t          rd_e;
    logic              memread_e;
    logic              br_taken_e;
    // Memory stage
    reg_idx_t          rd_m;
    logic              regwrite_m;
    logic              dmem_req_m;
    logic              dmem_ready;
    // Writeback stage
    reg_idx_t          rd_w;
    logic              regwrite_w;

    // Pipeline controls
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              stall_e;
    logic              flush_e;
    logic              stall_m;
    logic              flush_w;
    fwd_sel_e          fwd_a_e;
    fwd_sel_e          fwd_b_e;
    // Status and performance
    logic              mem_timeout;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_events;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, memread_e, br_taken_e,
               rd_m, regwrite_m, dmem_req_m, dmem_ready, rd_w, regwrite_w,
        input  stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w,
               fwd_a_e, fwd_b_e, mem_timeout, stall_cycles, flush_events
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, memread_e, br_taken_e,
               rd_m, regwrite_m, dmem_req_m, dmem_ready, rd_w, regwrite_w,
        output stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w,
               fwd_a_e, fwd_b_e, mem_timeout, stall_cycles, flush_events
    );

endinterface

// File: rtl/fwd_unit.sv
// Forwarding select for one EX-stage source operand.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  reg_idx_t rs_i,
    input  reg_idx_t rd_m_i,
    input  logic     regwrite_m_i,
    input  reg_idx_t rd_w_i,
    input  logic     regwrite_w_i,
    output fwd_sel_e sel_o
);

    // MEM holds the younger result, so it wins over WB when both target the same register
    always_comb begin
        sel_o = FWD_RF;
        if (regMatch(regwrite_m_i, rd_m_i, rs_i)) begin
            sel_o = FWD_MEM;
        end else if (regMatch(regwrite_w_i, rd_w_i, rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core: stall/flush
// priority, EX forwarding, data-memory freeze FSM with watchdog, and
// performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   hz
);

    localparam int WAIT_W_RAW = $clog2(TIMEOUT + 1);
    localparam int WAIT_W     = (WAIT_W_RAW < 8) ? 8 : WAIT_W_RAW;
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

    localparam logic [0:0] S_RUN      = RUN;
    localparam logic [0:0] S_MEM_WAIT = MEM_WAIT;

    logic              loadUse;
    logic              freeze;
    logic              stallF;
    logic              stallD;
    logic              flushD;
    logic              stallE;
    logic              flushE;
    logic              stallM;
    logic              flushW;
    fwd_sel_e          fwdA;
    fwd_sel_e          fwdB;

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [WAIT_W-1:0] waitCnt_q;
    logic [WAIT_W-1:0] waitCnt_d;
    logic              memTimeout_q;
    logic              memTimeout_d;
    logic [CNT_W-1:0]  stallCycles_q;
    logic [CNT_W-1:0]  stallCycles_d;
    logic [CNT_W-1:0]  flushEvents_q;
    logic [CNT_W-1:0]  flushEvents_d;

    fwd_unit uFwdA (
        .rs_i         (hz.rs1_e),
        .rd_m_i       (hz.rd_m),
        .regwrite_m_i (hz.regwrite_m),
        .rd_w_i       (hz.rd_w),
        .regwrite_w_i (hz.regwrite_w),
        .sel_o        (fwdA)
    );

    fwd_unit uFwdB (
        .rs_i         (hz.rs2_e),
        .rd_m_i       (hz.rd_m),
        .regwrite_m_i (hz.regwrite_m),
        .rd_w_i       (hz.rd_w),
        .regwrite_w_i (hz.regwrite_w),
        .sel_o        (fwdB)
    );

    // Raw hazard conditions: a load feeding the decode instruction, and a pending memory access
    always_comb begin
        loadUse = hz.memread_e && (hz.rd_e != '0) &&
                  ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
        freeze  = hz.dmem_req_m && !hz.dmem_ready;
    end

    // Resolve freeze > redirect > load-use; a held redirect fires once the freeze lifts
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        stallE = 1'b0;
        flushE = 1'b0;
        stallM = 1'b0;
        flushW = 1'b0;
        if (!rst) begin
            if (freeze) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (hz.br_taken_e) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (loadUse) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    // Freeze sequencer and watchdog; a dropped request without ready also returns to RUN
    always_comb begin
        state_d      = state_q;
        waitCnt_d    = '0;
        memTimeout_d = memTimeout_q;
        if (state_q == S_RUN) begin
            if (freeze) begin
                state_d = S_MEM_WAIT;
            end
        end else begin
            if (waitCnt_q != TIMEOUT_CNT) begin
                waitCnt_d = waitCnt_q + WAIT_W'(1);
            end else begin
                waitCnt_d = waitCnt_q;
            end
            if (waitCnt_d == TIMEOUT_CNT) begin
                memTimeout_d = 1'b1;
            end
            if (hz.dmem_ready || !hz.dmem_req_m) begin
                state_d = S_RUN;
            end
        end
    end

    // Performance counters wrap naturally at their width
    always_comb begin
        stallCycles_d = stallCycles_q + CNT_W'(stallD);
        flushEvents_d = flushEvents_q + CNT_W'(flushD);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RUN;
            waitCnt_q     <= '0;
            memTimeout_q  <= 1'b0;
            stallCycles_q <= '0;
            flushEvents_q <= '0;
        end else begin
            state_q       <= state_d;
            waitCnt_q     <= waitCnt_d;
            memTimeout_q  <= memTimeout_d;
            stallCycles_q <= stallCycles_d;
            flushEvents_q <= flushEvents_d;
        end
    end

    // Every output reads zero while reset is held
    assign hz.stall_f      = stallF;
    assign hz.stall_d      = stallD;
    assign hz.flush_d      = flushD;
    assign hz.stall_e      = stallE;
    assign hz.flush_e      = flushE;
    assign hz.stall_m      = stallM;
    assign hz.flush_w      = flushW;
    assign hz.fwd_a_e      = rst ? FWD_RF : fwdA;
    assign hz.fwd_b_e      = rst ? FWD_RF : fwdB;
    assign hz.mem_timeout  = memTimeout_q && !rst;
    assign hz.stall_cycles = rst ? '0 : stallCycles_q;
    assign hz.flush_events = rst ? '0 : flushEvents_q;

endmodule
